pdp8_mem_arbiter: RTL
=====================

PDP8_MEM_ARBITER -- requirements
Module: pdp8_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, memory word address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 12, memory word width.
REQ-003 SHALL have parameter MAX_WAIT, default 4, cycles an IFU request may be blocked before it takes priority.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset_n  in  1  synchronous, active-low reset.
REQ-006 ifu_rd_req  in  1  IFU read request, level, held until ifu_rd_valid.
REQ-007 ifu_rd_addr  in  ADDR_WIDTH  IFU read address, stable while requesting.
REQ-008 ifu_rd_data  out  DATA_WIDTH  IFU read data, meaningful when ifu_rd_valid.
REQ-009 ifu_rd_valid  out  1  one-cycle pulse, IFU read complete.
REQ-010 exec_rd_req / exec_rd_addr  in  1 / ADDR_WIDTH  execution-unit read request and address, held until exec_rd_valid.
REQ-011 exec_rd_data / exec_rd_valid  out  DATA_WIDTH / 1  execution-unit read data and one-cycle completion pulse.
REQ-012 exec_wr_req / exec_wr_addr / exec_wr_data  in  1 / ADDR_WIDTH / DATA_WIDTH  execution-unit write request, held until exec_wr_done.
REQ-013 exec_wr_done  out  1  one-cycle pulse, write committed.
REQ-014 mem_req / mem_we  out  1 / 1  single-port memory access strobe and write enable.
REQ-015 mem_addr / mem_wdata  out  ADDR_WIDTH / DATA_WIDTH  memory address and write data.
REQ-016 mem_rdata  in  DATA_WIDTH  memory read data, valid exactly one cycle after a read strobe.

Function
REQ-017 SHALL implement FSM states IDLE, IFU_RD, EXEC_RD, EXEC_WR, RESP.
REQ-018 IDLE: sample requests; on any pending request grant one, drive mem_req=1 with its address (mem_we=1 only for EXEC_WR) in the grant cycle, move to that grant state.
REQ-019 Grant state lasts one cycle; mem_req deasserted in all other states.
REQ-020 IFU_RD/EXEC_RD -> RESP: capture mem_rdata into requester data register, pulse matching valid in RESP, then RESP -> IDLE.
REQ-021 EXEC_WR -> RESP: pulse exec_wr_done in RESP, then RESP -> IDLE.
REQ-022 Throughput: one access per 3 cycles (grant, data, response); request-to-pulse latency 2 cycles when uncontested.
REQ-023 Priority: exec_wr_req > exec_rd_req > ifu_rd_req, except REQ-024.
REQ-024 Starvation counter (width clog2(MAX_WAIT+1)) increments each IDLE cycle ifu_rd_req is pending and not granted; at MAX_WAIT IFU wins next grant; counter clears on IFU grant or ifu_rd_req low.
REQ-025 Simultaneous exec_rd_req and exec_wr_req: write first (read-after-write ordering).
REQ-026 Request deasserted before grant: dropped, no pulse; request deasserted after grant: access completes, pulse still issued.
REQ-027 Data outputs hold last captured value until next capture of same requester.
REQ-028 At most one of ifu_rd_valid, exec_rd_valid, exec_wr_done high in any cycle.

Reset
REQ-029 reset_n low at clk edge: state=IDLE, starvation counter=0, all outputs 0 (data registers 0), regardless of access in flight.
REQ-030 Access interrupted by reset produces no completion pulse; requesters reissue.

Structure
REQ-031 State enum (arb_state_e) and ADDR_WIDTH/DATA_WIDTH macros SHALL live in pdp8_pkg.
REQ-032 Single module, no sub-modules; sits between instr_decode/instr_exec and memory_pdp in the full-chip top.

Verification
REQ-033 ifu_rd_req=1, addr 12'o0200, mem holds 12'o7402 -> mem_req at cycle 0, ifu_rd_valid cycle 2 with data 12'o7402.
REQ-034 exec_wr_req and exec_rd_req same cycle, both addr 12'o0050, wdata 12'o1234 -> write first, then exec_rd_data=12'o1234.
REQ-035 exec_rd_req held continuously plus ifu_rd_req, MAX_WAIT=4 -> IFU granted no later than its 5th IDLE-sampling cycle.
REQ-036 reset_n low cycle after IFU grant -> no ifu_rd_valid, outputs 0, FSM IDLE next cycle.
REQ-037 Random traffic assertion: mem_req never high two consecutive cycles; completion pulses mutually exclusive; every granted request completes once.

Source files
------------

// File: rtl/pdp8_pkg.sv
// pdp8_pkg: shared memory geometry and arbiter state encoding for the PDP-8 core.
package pdp8_pkg;

   localparam int PDP8_ADDR_WIDTH = 12;
   localparam int PDP8_DATA_WIDTH = 12;

   typedef enum logic [2:0] {
      IDLE,
      IFU_RD,
      EXEC_RD,
      EXEC_WR,
      RESP
   } arb_state_e;

endpackage

// File: rtl/pdp8_mem_arbiter.sv
// pdp8_mem_arbiter: shares one single-port memory between instruction fetch and execute.
// Grant is decided combinationally in IDLE, so an uncontested request strobes memory the same cycle.
module pdp8_mem_arbiter
   import pdp8_pkg::*;
#(
   parameter int ADDR_WIDTH = PDP8_ADDR_WIDTH,
   parameter int DATA_WIDTH = PDP8_DATA_WIDTH,
   parameter int MAX_WAIT   = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  ifu_rd_req,
   input  logic [ADDR_WIDTH-1:0] ifu_rd_addr,
   output logic [DATA_WIDTH-1:0] ifu_rd_data,
   output logic                  ifu_rd_valid,
   input  logic                  exec_rd_req,
   input  logic [ADDR_WIDTH-1:0] exec_rd_addr,
   output logic [DATA_WIDTH-1:0] exec_rd_data,
   output logic                  exec_rd_valid,
   input  logic                  exec_wr_req,
   input  logic [ADDR_WIDTH-1:0] exec_wr_addr,
   input  logic [DATA_WIDTH-1:0] exec_wr_data,
   output logic                  exec_wr_done,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   localparam int CW = $clog2(MAX_WAIT + 1);

   arb_state_e    state;
   logic [CW-1:0] wait_cnt;
   logic          idle, starved, ifu_win, grant_ifu, grant_rd, grant_wr;

   // Gating with reset_n keeps the memory strobe quiet while reset is held.
   always_comb begin
      idle      = reset_n && state == IDLE;
      starved   = wait_cnt == CW'(MAX_WAIT);
      ifu_win   = ifu_rd_req && (starved || !(exec_wr_req || exec_rd_req));
      grant_ifu = idle && ifu_win;
      grant_wr  = idle && !ifu_win && exec_wr_req;
      grant_rd  = idle && !ifu_win && !exec_wr_req && exec_rd_req;
      mem_req   = grant_ifu || grant_wr || grant_rd;
      mem_we    = grant_wr;
      mem_addr  = grant_wr ? exec_wr_addr : grant_rd ? exec_rd_addr : grant_ifu ? ifu_rd_addr : '0;
      mem_wdata = grant_wr ? exec_wr_data : '0;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state         <= IDLE;
         wait_cnt      <= '0;
         ifu_rd_data   <= '0;
         exec_rd_data  <= '0;
         ifu_rd_valid  <= 1'b0;
         exec_rd_valid <= 1'b0;
         exec_wr_done  <= 1'b0;
      end else begin
         ifu_rd_valid  <= 1'b0;
         exec_rd_valid <= 1'b0;
         exec_wr_done  <= 1'b0;
         wait_cnt      <= (!ifu_rd_req || grant_ifu) ? '0 :
                          (state == IDLE && !starved) ? wait_cnt + 1'b1 : wait_cnt;
         case (state)
            IDLE:    state <= grant_wr ? EXEC_WR : grant_rd ? EXEC_RD : grant_ifu ? IFU_RD : IDLE;
            IFU_RD: begin
               ifu_rd_data  <= mem_rdata;
               ifu_rd_valid <= 1'b1;
               state        <= RESP;
            end
            EXEC_RD: begin
               exec_rd_data  <= mem_rdata;
               exec_rd_valid <= 1'b1;
               state         <= RESP;
            end
            EXEC_WR: begin
               exec_wr_done <= 1'b1;
               state        <= RESP;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
